// File: rtl/obj_linebuf_dual_if.sv
// Sprite-engine write port of the dual line buffer: pointer control, pixel beats and ready.
interface obj_linebuf_dual_if #(
  parameter int unsigned PIX_W  = 4,
  parameter int unsigned ADDR_W = 8
);
  logic              hinv;
  logic              wr_load;
  logic [ADDR_W-1:0] wr_x;
  logic              wr_valid;
  logic [PIX_W-1:0]  wr_data;
  logic              wr_prio;
  logic              wr_ready;

  modport master (output hinv, wr_load, wr_x, wr_valid, wr_data, wr_prio, input  wr_ready);
  modport slave  (input  hinv, wr_load, wr_x, wr_valid, wr_data, wr_prio, output wr_ready);
endinterface

// File: rtl/obj_linebuf_dual.sv
// Double-buffered sprite line buffer: one bank filled by the sprite engine while the other
// is scanned out (and cleared behind the scan); banks swap on every line_start.
module obj_linebuf_dual #(
  parameter int unsigned PIX_W   = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TRANSP  = 0,
  parameter bit          PRIO_EN = 1'b1
) (
  input  logic               clkm_48MHZ,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic               line_start,
  obj_linebuf_dual_if.slave  wr,
  output logic [PIX_W-1:0]   pix_out,
  output logic               pix_prio,
  output logic               pix_opaque,
  output logic               collision
);

  localparam int unsigned N = 2 ** ADDR_W;
  localparam logic [PIX_W-1:0] TRANSP_PIX = PIX_W'(TRANSP);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q;
  logic              sel_q;
  logic [ADDR_W-1:0] rd_x_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              wr_ready_q;
  logic [PIX_W-1:0]  pix_out_q;
  logic              pix_prio_q;
  logic              pix_opaque_q;
  logic              collision_q;

  // Bank select is the MSB of the cell index: {bank, x}
  logic [PIX_W-1:0]  col_q  [2*N];
  logic              opq_q  [2*N];
  logic              prio_q [2*N];

  logic              run_c;
  logic              accept_c;
  logic [ADDR_W-1:0] base_c;
  logic [ADDR_W:0]   waddr_c;
  logic [ADDR_W:0]   raddr_c;
  logic              beat_opq_c;
  logic              hit_c;
  logic              we_c;
  logic              rd_c;

  always_comb begin
    run_c      = (state_q == S_RUN);
    accept_c   = run_c & wr.wr_valid & wr_ready_q;
    base_c     = wr.wr_load ? wr.wr_x : wr_ptr_q;
    waddr_c    = {sel_q, (wr.hinv ? ~base_c : base_c)};
    raddr_c    = {~sel_q, rd_x_q};
    beat_opq_c = (wr.wr_data != TRANSP_PIX);
    hit_c      = accept_c & beat_opq_c & opq_q[waddr_c];
    we_c       = accept_c & beat_opq_c &
                 (~opq_q[waddr_c] | (PRIO_EN & wr.wr_prio & ~prio_q[waddr_c]));
    rd_c       = run_c & ce_pix & ~line_start;
  end

  // Control, pointers and registered scan outputs
  always_ff @(posedge clkm_48MHZ or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      sel_q        <= 1'b0;
      rd_x_q       <= '0;
      wr_ptr_q     <= '0;
      clr_addr_q   <= '0;
      wr_ready_q   <= 1'b0;
      pix_out_q    <= TRANSP_PIX;
      pix_prio_q   <= 1'b0;
      pix_opaque_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == ADDR_W'(N - 1)) begin
            state_q    <= S_RUN;
            wr_ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Covers load-only, beat-only and load+beat (beat lands at wr_x, pointer wr_x+1)
          wr_ptr_q <= base_c + ADDR_W'(accept_c);
          if (line_start) begin
            sel_q       <= ~sel_q;
            rd_x_q      <= '0;
            collision_q <= 1'b0;
          end else begin
            if (hit_c) collision_q <= 1'b1;
            if (rd_c) begin
              pix_out_q    <= col_q[raddr_c];
              pix_prio_q   <= prio_q[raddr_c];
              pix_opaque_q <= opq_q[raddr_c];
              rd_x_q       <= rd_x_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Cell storage: power-up clear of both banks, then fill on the write bank, clear-behind-scan on the read bank
  always_ff @(posedge clkm_48MHZ) begin
    if (state_q == S_INIT) begin
      col_q [{1'b0, clr_addr_q}] <= TRANSP_PIX;
      opq_q [{1'b0, clr_addr_q}] <= 1'b0;
      prio_q[{1'b0, clr_addr_q}] <= 1'b0;
      col_q [{1'b1, clr_addr_q}] <= TRANSP_PIX;
      opq_q [{1'b1, clr_addr_q}] <= 1'b0;
      prio_q[{1'b1, clr_addr_q}] <= 1'b0;
    end else begin
      if (we_c) begin
        col_q [waddr_c] <= wr.wr_data;
        opq_q [waddr_c] <= 1'b1;
        prio_q[waddr_c] <= wr.wr_prio;
      end
      if (rd_c) begin
        col_q [raddr_c] <= TRANSP_PIX;
        opq_q [raddr_c] <= 1'b0;
        prio_q[raddr_c] <= 1'b0;
      end
    end
  end

  assign wr.wr_ready  = wr_ready_q;
  assign pix_out      = pix_out_q;
  assign pix_prio     = pix_prio_q;
  assign pix_opaque   = pix_opaque_q;
  assign collision    = collision_q;

endmodule

// File: doc/obj_linebuf_dual.md
Name: obj_linebuf_dual

Overview:
Parametrised double-buffered sprite line buffer; successor to the object-bus line-buffer pair.
- One bank is filled by the sprite engine while the other is scanned out to the mixer; the banks swap at every line_start.
- Adds over the previous generation: configurable pixel/line width, transparency gating, per-pixel priority, collision flag, clear-after-read, power-up bank clear.
- Sits between the object fetch/decode logic and the colour mixer.

Parameters:
PIX_W, 4, pixel colour-index width (bits)
ADDR_W, 8, line address width; line length N = 2^ADDR_W
TRANSP, 0, transparent pen value (never written, read-back of cleared cells)
PRIO_EN, 1, 1 = high-priority pixels may overwrite low-priority opaque pixels

Ports:
clkm_48MHZ  in  1  sole clock; all state on rising edge
reset  in  1  asynchronous, active-high
ce_pix  in  1  read-side pixel enable (one per displayed pixel)
line_start  in  1  one-clock pulse: swap banks, restart scan
hinv  in  1  horizontal mirror of write addresses
wr_load  in  1  load write pointer from wr_x
wr_x  in  ADDR_W  sprite start X
wr_valid  in  1  pixel beat present
wr_data  in  PIX_W  pixel colour
wr_prio  in  1  pixel priority
wr_ready  out  1  beat accepted when wr_valid & wr_ready
pix_out  out  PIX_W  scanned pixel
pix_prio  out  1  scanned pixel priority
pix_opaque  out  1  scanned pixel != TRANSP
collision  out  1  sticky: opaque beat landed on opaque cell this line

Behaviour:
- Reset (async): sel=0, rd_x=0, wr_ptr=0, collision=0, pix_out=TRANSP, pix_prio=0, pix_opaque=0, wr_ready=0, state=INIT, clr_addr=0.
- INIT state:
  - Each clock writes TRANSP / opaque=0 / prio=0 to clr_addr in both banks; clr_addr increments.
  - After address N-1 has been cleared, go to RUN.
  - Duration: exactly N clocks after reset release.
  - wr_ready=0; ce_pix and line_start are ignored.
- RUN state: wr_ready=1.
  - Write bank = sel; read bank = !sel.
- Write address: hinv ? ~wr_ptr : wr_ptr.
- Write pointer:
  - wr_load sets wr_ptr=wr_x. If wr_load and an accepted beat occur in the same clock, the beat uses wr_x and wr_ptr becomes wr_x+1.
  - Each accepted beat increments wr_ptr, transparent or not.
  - Wraps N-1 -> 0 modulo N, with no flag.
- Write gating (accepted beat):
  - Transparent (wr_data==TRANSP): no write.
  - Opaque, target cell transparent: write colour and prio.
  - Opaque, target cell opaque: write only if PRIO_EN & wr_prio & !cell_prio; in every case set collision=1.
  - Cell opaque/prio flags are held in register arrays per bank, so the gating decision is made in the same cycle.
- Read/scan, on ce_pix in RUN with no line_start:
  - Read the read bank at rd_x; register it onto pix_out/pix_prio/pix_opaque.
  - Latency: 1 clock after the ce_pix clock.
  - In the same clock, clear the cell (TRANSP, flags 0). Read-during-clear returns the old data.
  - rd_x increments and wraps modulo N.
  - Outputs hold between ce_pix pulses.
- line_start in RUN:
  - Toggles sel, rd_x=0, collision=0.
  - A beat accepted in the same clock goes to the pre-toggle write bank.
  - ce_pix in the same clock is ignored: no read, no clear.
  - wr_ptr is unchanged; the engine must issue wr_load.
- The two banks are physically separate, so write-side and clear-side accesses never conflict.
- Reset mid-line: immediate return to INIT; bank contents are re-cleared and in-flight beats are dropped.

Test Plan:
- Reset release, ADDR_W=8 -> wr_ready=0 for 256 clocks, then 1; after line_start, scanning 256 pixels gives pix_opaque=0 and pix_out=0 at every pixel.
- wr_load wr_x=10, beats 3,0,5 (prio 0), then line_start, then 16 ce_pix -> pix_out at x=10:3, x=11:0, x=12:5, all others 0; collision=0.
- Overlap: beat 7 at x=20 prio 0, then wr_load 20, beat 9 prio 1 -> x=20 reads 9 and collision=1. Same test with PRIO_EN=0 -> x=20 reads 7 and collision=1. Collision clears on next line_start.
- hinv=1, wr_load 0, beats 1,2 -> cells 255=1 and 254=2. wr_load 255 with hinv=0, beats 4,6 -> cells 255=4 and 0=6 (wrap).
- Clear-after-read: scan a filled line, then line_start twice with no writes, then rescan -> all pix_out=0.
- line_start coincident with an accepted beat 8 at x=3 and with ce_pix -> beat appears in the next scanned line at x=3; rd_x restarts at 0 with no skipped pixel.
